// File: rtl/ysyx_22041207_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_22041207_pipe_ctrl
//
// Purpose:
//   Central hazard and sequencing controller for the 5-stage RV64 pipeline
//   (IF, ID, EX, MEM, WB). It produces the flush/bubble controls for the
//   if_id, id_ex, ex_mem and mem_wb pipeline registers, the PC write enable
//   and the PC redirect mux select/target. It resolves load-use hazards,
//   branch/jump redirects, multi-cycle mul/div and memory stalls. It also
//   remembers a redirect that arrives while a fetch is still outstanding, so
//   that the stale fetch response can be thrown away before redirecting.
//
// Ports:
//   clk              pipeline clock; state updates on posedge
//   rst_n            asynchronous active-low reset
//   if_busy          fetch request outstanding
//   if_valid         fetch response delivered this cycle
//   id_rs1/id_rs2    ID source register indices
//   id_rs1_used/_rs2_used  ID actually reads that source
//   ex_rd            EX destination register index
//   ex_is_load       EX instruction is a load
//   ex_redirect      EX resolved a taken branch or jump
//   ex_redirect_pc   redirect target
//   ex_md_busy       mul/div unit still iterating
//   mem_busy         data memory access not complete
//   pc_we            PC register update enable
//   pc_redirect      select redirect_pc as the next PC
//   redirect_pc      redirect target to the PC mux
//   *_flush/*_bubble control of each pipeline register (flush wins)
//   state_o          current FSM state (RUN=0, DROP=1, REDIR=2)
//
// Configuration:
//   YSYX_22041207_PIPE_PERF_EN  adds 64-bit performance counters
//   perf_stall_cyc, perf_flush_cnt and perf_lu_cnt.
// ----------------------------------------------------------------------------
module ysyx_22041207_pipe_ctrl #(
   parameter int XLEN   = 64,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_busy,
   input  logic              if_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_is_load,
   input  logic              ex_redirect,
   input  logic [XLEN-1:0]   ex_redirect_pc,
   input  logic              ex_md_busy,
   input  logic              mem_busy,
   output logic              pc_we,
   output logic              pc_redirect,
   output logic [XLEN-1:0]   redirect_pc,
   output logic              if_id_flush,
   output logic              if_id_bubble,
   output logic              id_ex_flush,
   output logic              id_ex_bubble,
   output logic              ex_mem_flush,
   output logic              ex_mem_bubble,
   output logic              mem_wb_flush,
   output logic              mem_wb_bubble,
`ifdef YSYX_22041207_PIPE_PERF_EN
   output logic [63:0]       perf_stall_cyc,
   output logic [63:0]       perf_flush_cnt,
   output logic [63:0]       perf_lu_cnt,
`endif
   output logic [1:0]        state_o
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DROP  = 2'd1,
      ST_REDIR = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [XLEN-1:0]   r_target;
   logic              w_latch_target;
   logic              w_load_use;

   logic w_if_id_flush,  w_if_id_bubble;
   logic w_id_ex_flush,  w_id_ex_bubble;
   logic w_ex_mem_flush, w_ex_mem_bubble;
   logic w_mem_wb_flush, w_mem_wb_bubble;

   // A load in EX whose destination is read by ID must hold ID for one cycle,
   // except when the destination is x0, which never carries a real value.
   assign w_load_use = ex_is_load && (ex_rd != '0) &&
                       ((id_rs1_used && (id_rs1 == ex_rd)) ||
                        (id_rs2_used && (id_rs2 == ex_rd)));

   // State register and the pending redirect target. The target is only
   // captured when a redirect has to wait for an outstanding fetch; a reset
   // throws the pending target away.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_RUN;
         r_target <= '0;
      end else begin
         r_state <= w_next;
         if (w_latch_target) begin
            r_target <= ex_redirect_pc;
         end
      end
   end

   // Next-state and raw control outputs. In RUN the hazards are resolved in
   // strict priority: a memory stall freezes everything, then mul/div, then
   // redirects, then load-use. DROP waits for the stale fetch response to come
   // back and discards it; REDIR then steers the PC to the saved target.
   always_comb begin
      w_next          = r_state;
      w_latch_target  = 1'b0;
      pc_we           = 1'b1;
      pc_redirect     = 1'b0;
      redirect_pc     = '0;
      w_if_id_flush   = 1'b0;
      w_if_id_bubble  = 1'b0;
      w_id_ex_flush   = 1'b0;
      w_id_ex_bubble  = 1'b0;
      w_ex_mem_flush  = 1'b0;
      w_ex_mem_bubble = 1'b0;
      w_mem_wb_flush  = 1'b0;
      w_mem_wb_bubble = 1'b0;

      unique case (r_state)
         ST_RUN: begin
            if (mem_busy) begin
               pc_we           = 1'b0;
               w_if_id_bubble  = 1'b1;
               w_id_ex_bubble  = 1'b1;
               w_ex_mem_bubble = 1'b1;
               w_mem_wb_bubble = 1'b1;
            end else if (ex_md_busy) begin
               pc_we           = 1'b0;
               w_if_id_bubble  = 1'b1;
               w_id_ex_bubble  = 1'b1;
               w_ex_mem_bubble = 1'b1;
               w_mem_wb_flush  = 1'b1;
            end else if (ex_redirect) begin
               w_if_id_flush = 1'b1;
               w_id_ex_flush = 1'b1;
               if (!if_busy) begin
                  pc_redirect = 1'b1;
                  redirect_pc = ex_redirect_pc;
               end else begin
                  pc_we          = 1'b0;
                  w_latch_target = 1'b1;
                  w_next         = ST_DROP;
               end
            end else if (w_load_use) begin
               pc_we          = 1'b0;
               w_if_id_bubble = 1'b1;
               w_id_ex_flush  = 1'b1;
            end
         end

         ST_DROP: begin
            pc_we         = 1'b0;
            w_if_id_flush = 1'b1;
            if (mem_busy) begin
               w_ex_mem_bubble = 1'b1;
               w_mem_wb_bubble = 1'b1;
            end
            if (if_valid) begin
               w_next = ST_REDIR;
            end
         end

         ST_REDIR: begin
            pc_redirect   = 1'b1;
            redirect_pc   = r_target;
            w_if_id_flush = 1'b1;
            if (mem_busy) begin
               pc_we           = 1'b0;
               w_ex_mem_bubble = 1'b1;
               w_mem_wb_bubble = 1'b1;
            end else begin
               w_next = ST_RUN;
            end
         end

         default: begin
            w_next = ST_RUN;
         end
      endcase
   end

   // A flush already empties the register, so it always wins over a hold.
   assign if_id_flush   = w_if_id_flush;
   assign if_id_bubble  = w_if_id_bubble  & ~w_if_id_flush;
   assign id_ex_flush   = w_id_ex_flush;
   assign id_ex_bubble  = w_id_ex_bubble  & ~w_id_ex_flush;
   assign ex_mem_flush  = w_ex_mem_flush;
   assign ex_mem_bubble = w_ex_mem_bubble & ~w_ex_mem_flush;
   assign mem_wb_flush  = w_mem_wb_flush;
   assign mem_wb_bubble = w_mem_wb_bubble & ~w_mem_wb_flush;
   assign state_o       = r_state;

`ifdef YSYX_22041207_PIPE_PERF_EN
   logic [63:0] r_perf_stall;
   logic [63:0] r_perf_flush;
   logic [63:0] r_perf_lu;
   logic        w_redirect_accept;
   logic        w_lu_hit;

   assign w_redirect_accept = (r_state == ST_RUN) && !mem_busy && !ex_md_busy && ex_redirect;
   assign w_lu_hit          = (r_state == ST_RUN) && !mem_busy && !ex_md_busy && !ex_redirect &&
                              w_load_use;

   // Event counters; they simply wrap on overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_stall <= '0;
         r_perf_flush <= '0;
         r_perf_lu    <= '0;
      end else begin
         if (!pc_we) begin
            r_perf_stall <= r_perf_stall + 64'd1;
         end
         if (w_redirect_accept) begin
            r_perf_flush <= r_perf_flush + 64'd1;
         end
         if (w_lu_hit) begin
            r_perf_lu <= r_perf_lu + 64'd1;
         end
      end
   end

   assign perf_stall_cyc = r_perf_stall;
   assign perf_flush_cnt = r_perf_flush;
   assign perf_lu_cnt    = r_perf_lu;
`endif

endmodule

// File: tb/tb_ysyx_22041207_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22041207_pipe_ctrl
//
// Drives directed hazard scenarios followed by random traffic into the
// pipeline controller and compares every output on each falling edge against
// a rule-level model of the controller kept in this file.
// ----------------------------------------------------------------------------
module tb_ysyx_22041207_pipe_ctrl;

   logic        clk;
   logic        rstN;
   logic        ifBusy;
   logic        ifValid;
   logic [4:0]  idRs1;
   logic [4:0]  idRs2;
   logic        idRs1Used;
   logic        idRs2Used;
   logic [4:0]  exRd;
   logic        exIsLoad;
   logic        exRedirect;
   logic [63:0] exRedirectPc;
   logic        exMdBusy;
   logic        memBusy;

   logic        pcWe;
   logic        pcRedirect;
   logic [63:0] redirectPc;
   logic        ifIdFlush,  ifIdBubble;
   logic        idExFlush,  idExBubble;
   logic        exMemFlush, exMemBubble;
   logic        memWbFlush, memWbBubble;
   logic [1:0]  stateO;
`ifdef YSYX_22041207_PIPE_PERF_EN
   logic [63:0] perfStallCyc;
   logic [63:0] perfFlushCnt;
   logic [63:0] perfLuCnt;
`endif

   int total = 0;
   int bad   = 0;
   logic monitorOn = 1'b0;

   ysyx_22041207_pipe_ctrl #(.XLEN(64), .REG_AW(5)) dut (
      .clk            (clk),
      .rst_n          (rstN),
      .if_busy        (ifBusy),
      .if_valid       (ifValid),
      .id_rs1         (idRs1),
      .id_rs2         (idRs2),
      .id_rs1_used    (idRs1Used),
      .id_rs2_used    (idRs2Used),
      .ex_rd          (exRd),
      .ex_is_load     (exIsLoad),
      .ex_redirect    (exRedirect),
      .ex_redirect_pc (exRedirectPc),
      .ex_md_busy     (exMdBusy),
      .mem_busy       (memBusy),
      .pc_we          (pcWe),
      .pc_redirect    (pcRedirect),
      .redirect_pc    (redirectPc),
      .if_id_flush    (ifIdFlush),
      .if_id_bubble   (ifIdBubble),
      .id_ex_flush    (idExFlush),
      .id_ex_bubble   (idExBubble),
      .ex_mem_flush   (exMemFlush),
      .ex_mem_bubble  (exMemBubble),
      .mem_wb_flush   (memWbFlush),
      .mem_wb_bubble  (memWbBubble),
`ifdef YSYX_22041207_PIPE_PERF_EN
      .perf_stall_cyc (perfStallCyc),
      .perf_flush_cnt (perfFlushCnt),
      .perf_lu_cnt    (perfLuCnt),
`endif
      .state_o        (stateO)
   );

   // 100 MHz-style free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Reference model. "mode" says what the controller is doing: 0 running
   // normally, 1 waiting for a stale fetch to come back, 2 steering the PC to
   // the saved target. Bit order of flush/bubble: 0 if_id, 1 id_ex,
   // 2 ex_mem, 3 mem_wb.
   // ---------------------------------------------------------------------------
   typedef struct packed {
      logic        pcWe;
      logic        pcRedir;
      logic [63:0] rpc;
      logic [3:0]  flush;
      logic [3:0]  bubble;
      logic [1:0]  state;
   } exp_t;

   int          mode      = 0;
   logic [63:0] savedPc   = '0;
   longint      mStall    = 0;
   longint      mFlush    = 0;
   longint      mLu       = 0;

   function automatic bit modelLoadUse();
      bit hit1, hit2;
      hit1 = idRs1Used && (idRs1 == exRd);
      hit2 = idRs2Used && (idRs2 == exRd);
      return exIsLoad && (exRd != 5'd0) && (hit1 || hit2);
   endfunction

   function automatic exp_t modelOutputs();
      exp_t e;
      e       = '0;
      e.pcWe  = 1'b1;
      e.state = 2'(mode);
      if (mode == 0) begin
         if (memBusy) begin
            e.pcWe   = 1'b0;
            e.bubble = 4'b1111;
         end else if (exMdBusy) begin
            e.pcWe     = 1'b0;
            e.bubble   = 4'b0111;
            e.flush[3] = 1'b1;
         end else if (exRedirect) begin
            e.flush[1:0] = 2'b11;
            if (ifBusy) begin
               e.pcWe = 1'b0;
            end else begin
               e.pcRedir = 1'b1;
               e.rpc     = exRedirectPc;
            end
         end else if (modelLoadUse()) begin
            e.pcWe      = 1'b0;
            e.bubble[0] = 1'b1;
            e.flush[1]  = 1'b1;
         end
      end else if (mode == 1) begin
         e.pcWe     = 1'b0;
         e.flush[0] = 1'b1;
         if (memBusy) e.bubble[3:2] = 2'b11;
      end else begin
         e.pcRedir  = 1'b1;
         e.rpc      = savedPc;
         e.flush[0] = 1'b1;
         if (memBusy) begin
            e.pcWe        = 1'b0;
            e.bubble[3:2] = 2'b11;
         end
      end
      e.bubble = e.bubble & ~e.flush;
      return e;
   endfunction

   // Advance the model one clock; a reset forgets everything.
   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         mode    <= 0;
         savedPc <= '0;
         mStall  <= 0;
         mFlush  <= 0;
         mLu     <= 0;
      end else begin
         exp_t e;
         e = modelOutputs();
         assert (!(mode != 0 && exRedirect))
            else $error("[TB] illegal ex_redirect driven while a redirect is pending");
         if (!e.pcWe) mStall <= mStall + 1;
         if (mode == 0 && !memBusy && !exMdBusy && exRedirect) mFlush <= mFlush + 1;
         if (mode == 0 && !memBusy && !exMdBusy && !exRedirect && modelLoadUse()) mLu <= mLu + 1;
         if (mode == 0) begin
            if (!memBusy && !exMdBusy && exRedirect && ifBusy) begin
               savedPc <= exRedirectPc;
               mode    <= 1;
            end
         end else if (mode == 1) begin
            if (ifValid) mode <= 2;
         end else begin
            if (!memBusy) mode <= 0;
         end
      end
   end

   task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      e = modelOutputs();
      checkField("pc_we",         64'(pcWe),        64'(e.pcWe));
      checkField("pc_redirect",   64'(pcRedirect),  64'(e.pcRedir));
      checkField("redirect_pc",   redirectPc,       e.rpc);
      checkField("if_id_flush",   64'(ifIdFlush),   64'(e.flush[0]));
      checkField("id_ex_flush",   64'(idExFlush),   64'(e.flush[1]));
      checkField("ex_mem_flush",  64'(exMemFlush),  64'(e.flush[2]));
      checkField("mem_wb_flush",  64'(memWbFlush),  64'(e.flush[3]));
      checkField("if_id_bubble",  64'(ifIdBubble),  64'(e.bubble[0]));
      checkField("id_ex_bubble",  64'(idExBubble),  64'(e.bubble[1]));
      checkField("ex_mem_bubble", 64'(exMemBubble), 64'(e.bubble[2]));
      checkField("mem_wb_bubble", 64'(memWbBubble), 64'(e.bubble[3]));
      checkField("state_o",       64'(stateO),      64'(e.state));
   endtask

   // Continuous compare against the model, sampled on the falling edge where
   // the downstream stage registers sample these controls.
   always @(negedge clk) begin
      if (monitorOn) checkOutput();
   end

   // Pipeline completely quiet: PC advancing, no flush or hold anywhere.
   task automatic checkQuiet(input string tag);
      checkField({tag, "_pc_we"},   64'(pcWe), 64'd1);
      checkField({tag, "_pc_redir"}, 64'(pcRedirect), 64'd0);
      checkField({tag, "_ctl"},
                 64'({ifIdFlush, idExFlush, exMemFlush, memWbFlush,
                      ifIdBubble, idExBubble, exMemBubble, memWbBubble}), 64'd0);
   endtask

   task automatic applyIdle();
      ifBusy       = 1'b0;
      ifValid      = 1'b0;
      idRs1        = '0;
      idRs2        = '0;
      idRs1Used    = 1'b0;
      idRs2Used    = 1'b0;
      exRd         = '0;
      exIsLoad     = 1'b0;
      exRedirect   = 1'b0;
      exRedirectPc = '0;
      exMdBusy     = 1'b0;
      memBusy      = 1'b0;
   endtask

   // Random traffic; redirects only while the controller is running normally,
   // since EX is always flushed otherwise. Small register indices make
   // load-use collisions frequent.
   task automatic applyStimulus();
      ifBusy       = ($urandom_range(0, 2) == 0);
      ifValid      = ($urandom_range(0, 2) == 0);
      idRs1        = 5'($urandom_range(0, 3));
      idRs2        = 5'($urandom_range(0, 3));
      idRs1Used    = 1'($urandom);
      idRs2Used    = 1'($urandom);
      exRd         = 5'($urandom_range(0, 3));
      exIsLoad     = 1'($urandom);
      exRedirect   = (mode == 0) && ($urandom_range(0, 3) == 0);
      exRedirectPc = {$urandom, $urandom};
      exMdBusy     = ($urandom_range(0, 7) == 0);
      memBusy      = ($urandom_range(0, 5) == 0);
   endtask

   task automatic nextDrive();
      @(posedge clk);
      #1;
   endtask

   // Global time limit so the run always ends.
   initial begin
      #2_000_000;
      $display("[TB] FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      rstN = 1'b1;
      applyIdle();
      #1 rstN = 1'b0;

      // Reset state
      @(negedge clk);
      checkField("rst_state", 64'(stateO), 64'd0);
      checkField("rst_rpc",   redirectPc,  64'd0);
      checkQuiet("rst");
      nextDrive();
      rstN = 1'b1;
      monitorOn = 1'b1;

      // Load-use on rs1: one held cycle, then free once the load leaves EX
      nextDrive();
      applyIdle();
      exIsLoad = 1'b1; exRd = 5'd5; idRs1 = 5'd5; idRs1Used = 1'b1;
      @(negedge clk);
      checkField("lu_pc_we",     64'(pcWe),       64'd0);
      checkField("lu_ifid_bub",  64'(ifIdBubble), 64'd1);
      checkField("lu_idex_fl",   64'(idExFlush),  64'd1);
      nextDrive();
      exIsLoad = 1'b0;
      @(negedge clk);
      checkQuiet("lu_after");

      // Load into x0 never stalls
      nextDrive();
      applyIdle();
      exIsLoad = 1'b1; exRd = 5'd0; idRs1 = 5'd0; idRs1Used = 1'b1;
      @(negedge clk);
      checkQuiet("x0_load");

      // Redirect with fetch idle: taken in the same cycle
      nextDrive();
      applyIdle();
      exRedirect = 1'b1; exRedirectPc = 64'h8000_0040;
      @(negedge clk);
      checkField("rdi_pc_redir", 64'(pcRedirect), 64'd1);
      checkField("rdi_pc_we",    64'(pcWe),       64'd1);
      checkField("rdi_rpc",      redirectPc,      64'h8000_0040);
      checkField("rdi_flush",    64'({ifIdFlush, idExFlush}), 64'b11);
      nextDrive();
      applyIdle();
      @(negedge clk);
      checkField("rdi_state", 64'(stateO), 64'd0);

      // Redirect with fetch busy: DROP until the response, then REDIR, then RUN
      nextDrive();
      exRedirect = 1'b1; exRedirectPc = 64'h8000_1000; ifBusy = 1'b1;
      @(negedge clk);
      checkField("rdb_pc_we", 64'(pcWe), 64'd0);
      for (int c = 1; c <= 3; c++) begin
         nextDrive();
         applyIdle();
         ifBusy  = (c < 3);
         ifValid = (c == 3);
         @(negedge clk);
         checkField("drop_state", 64'(stateO),    64'd1);
         checkField("drop_flush", 64'(ifIdFlush), 64'd1);
         checkField("drop_pc_we", 64'(pcWe),      64'd0);
      end
      nextDrive();
      applyIdle();
      @(negedge clk);
      checkField("redir_state", 64'(stateO),     64'd2);
      checkField("redir_pc_we", 64'(pcWe),       64'd1);
      checkField("redir_sel",   64'(pcRedirect), 64'd1);
      checkField("redir_rpc",   redirectPc,      64'h8000_1000);
      nextDrive();
      @(negedge clk);
      checkField("redir_back", 64'(stateO), 64'd0);
      checkQuiet("redir_back");

      // Memory stall holds off a pending redirect until it clears
      for (int c = 0; c < 4; c++) begin
         nextDrive();
         applyIdle();
         memBusy = 1'b1; exRedirect = 1'b1; exRedirectPc = 64'h8000_2000;
         @(negedge clk);
         checkField("ms_pc_we",  64'(pcWe), 64'd0);
         checkField("ms_bubble", 64'({ifIdBubble, idExBubble, exMemBubble, memWbBubble}), 64'hf);
         checkField("ms_flush",  64'({ifIdFlush, idExFlush, exMemFlush, memWbFlush}), 64'h0);
      end
      nextDrive();
      memBusy = 1'b0;
      @(negedge clk);
      checkField("ms_taken_sel", 64'(pcRedirect), 64'd1);
      checkField("ms_taken_rpc", redirectPc,      64'h8000_2000);
      checkField("ms_taken_we",  64'(pcWe),       64'd1);

      // Reset in the middle of DROP
      nextDrive();
      applyIdle();
      exRedirect = 1'b1; exRedirectPc = 64'h8000_3000; ifBusy = 1'b1;
      nextDrive();
      applyIdle();
      ifBusy = 1'b1;
      @(negedge clk);
      checkField("mid_drop_state", 64'(stateO), 64'd1);
      #2;
      applyIdle();
      rstN = 1'b0;
      #1;
      checkField("mid_rst_state", 64'(stateO), 64'd0);
      checkField("mid_rst_rpc",   redirectPc,  64'd0);
      nextDrive();
      rstN = 1'b1;
      @(negedge clk);
      checkQuiet("mid_rst_after");

      // Random traffic, with an occasional reset
      for (int i = 0; i < 3000; i++) begin
         nextDrive();
         if ($urandom_range(0, 299) == 0) begin
            applyIdle();
            rstN = 1'b0;
            nextDrive();
            rstN = 1'b1;
         end else begin
            applyStimulus();
         end
      end

      nextDrive();
      applyIdle();
      @(negedge clk);
      monitorOn = 1'b0;
`ifdef YSYX_22041207_PIPE_PERF_EN
      checkField("perf_stall", perfStallCyc, 64'(mStall));
      checkField("perf_flush", perfFlushCnt, 64'(mFlush));
      checkField("perf_lu",    perfLuCnt,    64'(mLu));
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ysyx_22041207_pipe_ctrl.md
Name: ysyx_22041207_pipe_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV64 pipeline (IF, ID, EX, MEM, WB). It drives the flush/bubble (hold) inputs of every pipeline register (if_id, id_ex, ex_mem, mem_wb) and the PC write-enable and redirect mux. It resolves load-use hazards, branch/jump redirects, multi-cycle EX ops (mul/div) and memory stalls. It also tracks a redirect that arrives while an instruction fetch is still outstanding, so that the stale fetch response is discarded.

Parameters:
XLEN, 64, PC / redirect target width
REG_AW, 5, register index width

Ports:
clk  input  1  pipeline clock; state updates on posedge; downstream stage registers sample the control outputs on negedge
rst_n  input  1  asynchronous, active-low reset
if_busy  input  1  fetch request outstanding; response not yet returned
if_valid  input  1  fetch response delivered this cycle
id_rs1  input  REG_AW  ID source 1 index
id_rs2  input  REG_AW  ID source 2 index
id_rs1_used  input  1  ID reads rs1
id_rs2_used  input  1  ID reads rs2
ex_rd  input  REG_AW  EX destination index
ex_is_load  input  1  EX instruction is a load
ex_redirect  input  1  EX resolved taken branch or jump
ex_redirect_pc  input  XLEN  redirect target
ex_md_busy  input  1  mul/div unit still iterating
mem_busy  input  1  data memory access not complete
pc_we  output  1  PC register update enable
pc_redirect  output  1  select redirect_pc as next PC
redirect_pc  output  XLEN  redirect target to PC mux
if_id_flush / if_id_bubble  output  1 each  if_id control
id_ex_flush / id_ex_bubble  output  1 each  id_ex control
ex_mem_flush / ex_mem_bubble  output  1 each  ex_mem control
mem_wb_flush / mem_wb_bubble  output  1 each  mem_wb control
state_o  output  2  current FSM state (debug)

Behaviour:
- Outputs are combinational from the current state and inputs. State and the redirect_pc register update on posedge clk.
- Reset (rst_n=0, asynchronous): state=RUN, pending target=0. All flush/bubble=0, pc_we=1, pc_redirect=0, redirect_pc=0.
- load_use = ex_is_load & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- Priority in RUN, first match wins:
  1. mem_busy: all four *_bubble=1, pc_we=0. This freezes the whole pipe, and any redirect or hazard waits.
  2. ex_md_busy: if_id/id_ex/ex_mem bubble=1, mem_wb_flush=1, pc_we=0.
  3. ex_redirect:
     - if_id_flush=1, id_ex_flush=1.
     - If if_busy=0: pc_we=1, pc_redirect=1, redirect_pc=ex_redirect_pc; stay in RUN.
     - If if_busy=1: latch ex_redirect_pc, pc_we=0, go to DROP.
     - ex_redirect overrides load_use.
  4. load_use: pc_we=0, if_id_bubble=1, id_ex_flush=1. Exactly one bubble is inserted; the next cycle proceeds when the load has left EX.
  5. otherwise: pc_we=1, no flush/bubble.
- DROP (waiting for the stale fetch):
  - if_id_flush=1 every cycle; pc_we=0.
  - On if_valid=1, the response is discarded; go to REDIR.
  - mem_busy still bubbles ex_mem and mem_wb. It does not block the DROP exit.
- REDIR:
  - pc_we=1, pc_redirect=1, redirect_pc=latched target, if_id_flush=1; go to RUN.
  - If mem_busy=1, hold in REDIR with pc_we=0.
- A new ex_redirect while in DROP/REDIR is ignored. EX has already been flushed, so it cannot occur legally; the bench asserts on it.
- The *_flush and *_bubble outputs of the same register are never both 1. When both would apply, flush wins.
- A reset mid-DROP or mid-REDIR returns to RUN and loses the pending target.

Optional Feature:
YSYX_22041207_PIPE_PERF_EN:
- Defined: adds 64-bit outputs perf_stall_cyc (cycles with pc_we=0), perf_flush_cnt (count of ex_redirect accepted) and perf_lu_cnt (load-use bubbles). All are cleared by rst_n and wrap at 2^64.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> for one cycle pc_we=0, if_id_bubble=1, id_ex_flush=1; the next cycle (ex_is_load=0) gives pc_we=1.
- rd=x0 load: ex_rd=0, id_rs1=0, id_rs1_used=1 -> no bubble, pc_we=1.
- Redirect, fetch idle: ex_redirect=1, ex_redirect_pc=0x80000040, if_busy=0 -> the same cycle gives pc_redirect=1, redirect_pc=0x80000040, if_id_flush=id_ex_flush=1; state stays RUN.
- Redirect, fetch busy: ex_redirect=1, ex_redirect_pc=0x80001000, if_busy=1 -> state DROP with if_id_flush held. After if_valid pulses 3 cycles later: REDIR for one cycle with redirect_pc=0x80001000 and pc_we=1, then RUN.
- Memory stall vs redirect: mem_busy=1 and ex_redirect=1 for 4 cycles -> all bubbles=1, pc_we=0, no flush. When mem_busy drops, the redirect is taken that cycle.
- Reset mid-DROP: pull rst_n low in DROP -> state_o=RUN immediately and redirect_pc=0. After release with no requests: pc_we=1 and all flush/bubble=0.
